rr_hold_arbiter: RTL

Registered round-robin arbiter that shares one downstream resource among N requesters with grant hold. Once granted, a requester owns the resource until it signals `last`, drops its request, or exceeds a bounded hold time. It is the fairness-oriented successor to the team's fixed-priority lowest-bit arbiter and sits between requester ports and the shared datapath mux select.

---
 rtl/rr_hold_arbiter_pkg.sv | 9 +
 rtl/rr_hold_arbiter_if.sv | 24 ++
 rtl/rr_hold_arbiter_pick.sv | 41 ++++
 rtl/rr_hold_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types and defaults for the round-robin hold arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Requester-side bundle: request/last in, registered grant information out.
interface rr_hold_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req;
  logic           last;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;

  modport master (
    output req, last,
    input  grant, grant_valid, grant_id, preempt
  );

  modport slave (
    input  req, last,
    output grant, grant_valid, grant_id, preempt
  );

endinterface

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           any
);

  localparam logic [IDW:0] N_EXT = (IDW+1)'(N);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [IDW-1:0] offset;
  logic [IDW:0]   sum;

  // Rotating the doubled vector puts requester ptr at bit 0, so the lowest
  // set bit of the rotated window is the round-robin winner.
  always_comb begin
    doubled = {req, req};
    shifted = doubled >> ptr;
    rot     = shifted[N-1:0];
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offset = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_EXT) sum = sum - N_EXT;
    pick_id = sum[IDW-1:0];
    any     = |req;
    pick    = '0;
    if (any) pick[pick_id] = 1'b1;
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant hold, release on last/drop/timeout,
// and a mandatory idle cycle between grants.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  parameter int IDW      = $clog2(N)
) (
  input logic              clk,
  input logic              rst_n,
  rr_hold_arbiter_if.slave bus
);

  localparam int             HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;
  logic           preempt_q, preempt_d;

  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;
  logic           any;

  logic owner_req;
  logic at_limit;
  logic release_now;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  assign owner_req   = bus.req[id_q];
  assign at_limit    = (hcnt_q == HOLD_LAST);
  assign release_now = !owner_req || bus.last || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  // Preempt only flags a pure timeout; a coincident last or request drop
  // counts as an ordinary release.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    grant_d   = grant_q;
    id_d      = id_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        id_d    = '0;
        hcnt_d  = '0;
        if (any) begin
          grant_d = pick;
          id_d    = pick_id;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_d   = '0;
          id_d      = '0;
          hcnt_d    = '0;
          ptr_d     = (id_q == ID_LAST) ? '0 : id_q + IDW'(1);
          preempt_d = at_limit && owner_req && !bus.last;
          state_d   = IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |grant_d;
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = id_q;
  assign bus.preempt     = preempt_q;

endmodule
